// File: rtl/bsg_manycore_host_req_bridge.sv
// Host endpoint on the manycore IO link: packs four host words into a request and issues it under credits,
// buffers responses for the host, and drains incoming requests. Optional timeout: BSG_MANYCORE_HOST_BRIDGE_TIMEOUT_EN.
module bsg_manycore_host_req_bridge #(
    parameter int addr_width_p      = 28,
    parameter int data_width_p      = 32,
    parameter int x_cord_width_p    = 4,
    parameter int y_cord_width_p    = 3,
    parameter int src_x_p           = 0,
    parameter int src_y_p           = 0,
    parameter int max_out_credits_p = 16,
    parameter int resp_fifo_els_p   = 4,
    localparam int fwd_pkt_width_lp  = addr_width_p + 2 + 4 + 5 + data_width_p
                                       + 2 * (x_cord_width_p + y_cord_width_p),
    localparam int rev_pkt_width_lp  = data_width_p + 5 + x_cord_width_p + y_cord_width_p,
    localparam int link_sif_width_lp = fwd_pkt_width_lp + rev_pkt_width_lp + 6,
    localparam int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         host_v_i,
    input  logic [31:0]                  host_data_i,
    output logic                         host_ready_o,
    output logic                         resp_v_o,
    output logic [data_width_p-1:0]      resp_data_o,
    output logic [4:0]                   resp_reg_id_o,
    input  logic                         resp_yumi_i,
    input  logic [link_sif_width_lp-1:0] link_sif_i,
    output logic [link_sif_width_lp-1:0] link_sif_o,
    output logic [credit_width_lp-1:0]   out_credits_o,
`ifdef BSG_MANYCORE_HOST_BRIDGE_TIMEOUT_EN
    output logic                         timeout_o,
`endif
    output logic [15:0]                  drop_count_o
);

    localparam int lg_els_lp = $clog2(resp_fifo_els_p);
    localparam int ptr_w_lp  = lg_els_lp + 1;
    localparam logic [credit_width_lp-1:0] max_credits_lp = credit_width_lp'(max_out_credits_p);

    typedef enum logic [0:0] {COLLECT, SEND} state_e;

    // Link layout, MSB first: fwd {v, packet, ready_and_rev}, then rev {v, packet, ready_and_rev}
    logic                        in_fwd_v;
    logic [fwd_pkt_width_lp-1:0] unused_in_fwd_pkt;
    logic                        out_fwd_ready;
    logic                        in_rev_v;
    logic [rev_pkt_width_lp-1:0] in_rev_pkt;
    logic                        unused_in_rev_ready;
    logic [data_width_p-1:0]     rev_data;
    logic [4:0]                  rev_load_id;
    logic [y_cord_width_p-1:0]   unused_rev_y;
    logic [x_cord_width_p-1:0]   unused_rev_x;
    logic                        unused_ok;

    assign {in_fwd_v, unused_in_fwd_pkt, out_fwd_ready,
            in_rev_v, in_rev_pkt, unused_in_rev_ready} = link_sif_i;
    assign {rev_data, rev_load_id, unused_rev_y, unused_rev_x} = in_rev_pkt;
    assign unused_ok = ^{unused_in_fwd_pkt, unused_in_rev_ready, unused_rev_y, unused_rev_x, host_data_i};

    state_e                      state_q;
    logic                        host_ready_q;
    logic [1:0]                  word_cnt_q;
    logic [addr_width_p-1:0]     addr_q;
    logic [data_width_p-1:0]     data_q;
    logic [x_cord_width_p-1:0]   dst_x_q;
    logic [y_cord_width_p-1:0]   dst_y_q;
    logic [3:0]                  mask_q;
    logic [1:0]                  op_q;
    logic [4:0]                  reg_id_q;
    logic [credit_width_lp-1:0]  credits_q, credits_d;
    logic [15:0]                 drop_cnt_q, drop_cnt_d;
    logic [ptr_w_lp-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [data_width_p+4:0]     fifo_mem_q [resp_fifo_els_p];

    logic                        fwd_v, fwd_hs, rev_hs, fifo_full, fifo_empty, push, pop;
    logic [fwd_pkt_width_lp-1:0] fwd_pkt;

    assign fwd_v  = (state_q == SEND) && (credits_q != '0);
    assign fwd_hs = fwd_v && out_fwd_ready;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[ptr_w_lp-1] != rd_ptr_q[ptr_w_lp-1])
                     && (wr_ptr_q[lg_els_lp-1:0] == rd_ptr_q[lg_els_lp-1:0]);
    assign rev_hs     = in_rev_v && !fifo_full;
    assign push       = rev_hs;
    assign pop        = resp_yumi_i && !fifo_empty;

    assign fwd_pkt = {addr_q, op_q, mask_q, reg_id_q, data_q,
                      y_cord_width_p'(src_y_p), x_cord_width_p'(src_x_p), dst_y_q, dst_x_q};

    assign link_sif_o = {fwd_v, fwd_pkt, 1'b1,
                         1'b0, {rev_pkt_width_lp{1'b0}}, !fifo_full};

    assign host_ready_o  = host_ready_q;
    assign out_credits_o = credits_q;
    assign drop_count_o  = drop_cnt_q;
    assign resp_v_o      = !fifo_empty;
    assign {resp_data_o, resp_reg_id_o} = fifo_mem_q[rd_ptr_q[lg_els_lp-1:0]];

    // Word collection and packet issue; the held fields form the packet and stay frozen during SEND
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= COLLECT;
            host_ready_q <= 1'b1;
            word_cnt_q   <= 2'd0;
            addr_q       <= '0;
            data_q       <= '0;
            dst_x_q      <= '0;
            dst_y_q      <= '0;
            mask_q       <= '0;
            op_q         <= '0;
            reg_id_q     <= '0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (host_v_i && host_ready_q) begin
                        case (word_cnt_q)
                            2'd0: addr_q <= host_data_i[addr_width_p-1:0];
                            2'd1: data_q <= host_data_i[data_width_p-1:0];
                            2'd2: begin
                                dst_x_q <= host_data_i[x_cord_width_p-1:0];
                                dst_y_q <= host_data_i[16 +: y_cord_width_p];
                            end
                            default: begin
                                mask_q   <= host_data_i[3:0];
                                op_q     <= host_data_i[9:8];
                                reg_id_q <= host_data_i[20:16];
                            end
                        endcase
                        word_cnt_q <= word_cnt_q + 2'd1;
                        if (word_cnt_q == 2'd3) begin
                            state_q      <= SEND;
                            host_ready_q <= 1'b0;
                        end
                    end
                end
                SEND: begin
                    if (fwd_hs) begin
                        state_q      <= COLLECT;
                        host_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= COLLECT;
                    host_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        credits_d = credits_q;
        if (fwd_hs && !rev_hs)
            credits_d = credits_q - 1'b1;
        else if (rev_hs && !fwd_hs)
            credits_d = credits_q + 1'b1;

        drop_cnt_d = drop_cnt_q;
        if (in_fwd_v && (drop_cnt_q != 16'hFFFF))
            drop_cnt_d = drop_cnt_q + 16'd1;

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q  <= max_credits_lp;
            drop_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < resp_fifo_els_p; i++)
                fifo_mem_q[i] <= '0;
        end else begin
            credits_q  <= credits_d;
            drop_cnt_q <= drop_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            if (push)
                fifo_mem_q[wr_ptr_q[lg_els_lp-1:0]] <= {rev_data, rev_load_id};
        end
    end

`ifndef SYNTHESIS
    // A response with every credit already home means the manycore returned something never requested
    always_ff @(posedge clk_i) begin
        if (reset_n_i)
            assert (!(rev_hs && !fwd_hs && (credits_q == max_credits_lp)));
    end
`endif

`ifdef BSG_MANYCORE_HOST_BRIDGE_TIMEOUT_EN
    logic [19:0] timeout_cnt_q;
    logic        timeout_q;

    // Measures silence on the response channel while requests are outstanding
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timeout_cnt_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            if (rev_hs || (credits_q == max_credits_lp))
                timeout_cnt_q <= '0;
            else if (timeout_cnt_q != 20'hFFFFF)
                timeout_cnt_q <= timeout_cnt_q + 20'd1;
            if (timeout_cnt_q == 20'hFFFFF)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_bsg_manycore_host_req_bridge.sv
// Directed self-checking bench for bsg_manycore_host_req_bridge (default build, timeout feature off).
module tb_bsg_manycore_host_req_bridge;

    localparam int FwdPktW = 85;
    localparam int RevPktW = 44;
    localparam int LinkW   = FwdPktW + RevPktW + 6;

    logic              clk;
    logic              resetN;
    logic              hostV;
    logic [31:0]       hostData;
    logic              hostReady;
    logic              respV;
    logic [31:0]       respData;
    logic [4:0]        respRegId;
    logic              respYumi;
    logic [LinkW-1:0]  linkSifI;
    logic [LinkW-1:0]  linkSifO;
    logic [4:0]        outCredits;
    logic [15:0]       dropCount;

    logic               inFwdV;
    logic [FwdPktW-1:0] inFwdPkt;
    logic               fwdReadyIn;
    logic               inRevV;
    logic [RevPktW-1:0] inRevPkt;

    logic               outFwdV;
    logic [FwdPktW-1:0] outFwdPkt;
    logic               outFwdReady;
    logic               outRevV;
    logic [RevPktW-1:0] outRevPkt;
    logic               outRevReady;

    logic [FwdPktW-1:0] expPkt;
    int assertCount = 0;
    int failCount   = 0;

    assign linkSifI = {inFwdV, inFwdPkt, fwdReadyIn, inRevV, inRevPkt, 1'b0};
    assign {outFwdV, outFwdPkt, outFwdReady, outRevV, outRevPkt, outRevReady} = linkSifO;

    bsg_manycore_host_req_bridge dut (
        .clk_i         (clk),
        .reset_n_i     (resetN),
        .host_v_i      (hostV),
        .host_data_i   (hostData),
        .host_ready_o  (hostReady),
        .resp_v_o      (respV),
        .resp_data_o   (respData),
        .resp_reg_id_o (respRegId),
        .resp_yumi_i   (respYumi),
        .link_sif_i    (linkSifI),
        .link_sif_o    (linkSifO),
        .out_credits_o (outCredits),
        .drop_count_o  (dropCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        int n;
        n = 0;
        hostV    = 1'b1;
        hostData = word;
        while (!hostReady && n < 20) begin
            tick();
            n++;
        end
        if (!hostReady)
            checkOutput("hostReadyWait", {127'd0, hostReady}, 128'd1);
        tick();
        hostV = 1'b0;
    endtask

    task automatic issueRequest(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        int n;
        applyStimulus(w0);
        applyStimulus(w1);
        applyStimulus(w2);
        applyStimulus(w3);
        n = 0;
        while (!outFwdV && n < 20) begin
            tick();
            n++;
        end
        if (!outFwdV)
            checkOutput("fwdValidWait", {127'd0, outFwdV}, 128'd1);
        tick();
    endtask

    task automatic returnResponse(input logic [31:0] data, input logic [4:0] id);
        inRevV   = 1'b1;
        inRevPkt = {data, id, 3'd0, 4'd0};
        tick();
        inRevV = 1'b0;
    endtask

    initial begin
        resetN     = 1'b0;
        hostV      = 1'b0;
        hostData   = '0;
        respYumi   = 1'b0;
        inFwdV     = 1'b0;
        inFwdPkt   = '0;
        fwdReadyIn = 1'b0;
        inRevV     = 1'b0;
        inRevPkt   = '0;

        // Reset state
        tick();
        tick();
        checkOutput("rstHostReady", {127'd0, hostReady}, 128'd1);
        checkOutput("rstRespV", {127'd0, respV}, 128'd0);
        checkOutput("rstFwdV", {127'd0, outFwdV}, 128'd0);
        checkOutput("rstRevReady", {127'd0, outRevReady}, 128'd1);
        checkOutput("rstFwdReady", {127'd0, outFwdReady}, 128'd1);
        checkOutput("rstRevV", {127'd0, outRevV}, 128'd0);
        checkOutput("rstRevPkt", {84'd0, outRevPkt}, 128'd0);
        checkOutput("rstCredits", {123'd0, outCredits}, 128'd16);
        checkOutput("rstDrop", {112'd0, dropCount}, 128'd0);
        resetN = 1'b1;
        tick();

        // First packet, held 5 cycles by backpressure
        applyStimulus(32'h0000_0100);
        applyStimulus(32'hDEAD_BEEF);
        applyStimulus(32'h0002_0001);
        applyStimulus(32'h0003_010F);
        expPkt = {28'h100, 2'b01, 4'hF, 5'd3, 32'hDEADBEEF, 3'd0, 4'd0, 3'd2, 4'd1};
        for (int i = 0; i < 5; i++) begin
            checkOutput("holdFwdV", {127'd0, outFwdV}, 128'd1);
            checkOutput("holdPkt", {43'd0, outFwdPkt}, {43'd0, expPkt});
            checkOutput("holdHostReady", {127'd0, hostReady}, 128'd0);
            tick();
        end
        fwdReadyIn = 1'b1;
        checkOutput("hsFwdV", {127'd0, outFwdV}, 128'd1);
        tick();
        checkOutput("afterHsFwdV", {127'd0, outFwdV}, 128'd0);
        checkOutput("afterHsHostReady", {127'd0, hostReady}, 128'd1);
        checkOutput("afterHsCredits", {123'd0, outCredits}, 128'd15);

        // Incoming requests are drained and counted
        inFwdV = 1'b1;
        tick();
        tick();
        tick();
        inFwdV = 1'b0;
        checkOutput("dropCount", {112'd0, dropCount}, 128'd3);
        checkOutput("fwdReadyAlways", {127'd0, outFwdReady}, 128'd1);

        // Exhaust credits
        for (int i = 1; i < 16; i++)
            issueRequest(32'h200 + i, 32'h5000 + i, 32'h0001_0002, 32'h0004_0103);
        checkOutput("creditsZero", {123'd0, outCredits}, 128'd0);
        applyStimulus(32'h0000_0300);
        applyStimulus(32'h0000_0301);
        applyStimulus(32'h0000_0001);
        applyStimulus(32'h0001_010F);
        for (int i = 0; i < 3; i++) begin
            checkOutput("starvedFwdV", {127'd0, outFwdV}, 128'd0);
            checkOutput("starvedHostReady", {127'd0, hostReady}, 128'd0);
            tick();
        end
        returnResponse(32'hCAFE_0001, 5'd9);
        checkOutput("creditBackFwdV", {127'd0, outFwdV}, 128'd1);
        checkOutput("creditBackCredits", {123'd0, outCredits}, 128'd1);
        tick();
        checkOutput("issued17Credits", {123'd0, outCredits}, 128'd0);
        checkOutput("issued17FwdV", {127'd0, outFwdV}, 128'd0);
        checkOutput("issued17HostReady", {127'd0, hostReady}, 128'd1);
        checkOutput("resp0V", {127'd0, respV}, 128'd1);
        checkOutput("resp0Data", {96'd0, respData}, 128'hCAFE_0001);
        checkOutput("resp0Id", {123'd0, respRegId}, 128'd9);
        respYumi = 1'b1;
        tick();
        respYumi = 1'b0;
        checkOutput("resp0Popped", {127'd0, respV}, 128'd0);

        // Fill the response FIFO, then a fifth response waits for a pop
        for (int i = 0; i < 4; i++)
            returnResponse(32'h1000_0000 + i, 5'(i + 1));
        checkOutput("fullRevReady", {127'd0, outRevReady}, 128'd0);
        checkOutput("fullCredits", {123'd0, outCredits}, 128'd4);
        inRevV   = 1'b1;
        inRevPkt = {32'h1000_0004, 5'd5, 3'd0, 4'd0};
        tick();
        checkOutput("fullRejectCredits", {123'd0, outCredits}, 128'd4);
        respYumi = 1'b1;
        checkOutput("fullHeadData", {96'd0, respData}, 128'h1000_0000);
        tick();
        respYumi = 1'b0;
        checkOutput("popReopenReady", {127'd0, outRevReady}, 128'd1);
        checkOutput("popNoPushCredits", {123'd0, outCredits}, 128'd4);
        tick();
        inRevV = 1'b0;
        checkOutput("fifthCredits", {123'd0, outCredits}, 128'd5);
        checkOutput("fifthFullAgain", {127'd0, outRevReady}, 128'd0);
        for (int i = 1; i < 5; i++) begin
            checkOutput("orderV", {127'd0, respV}, 128'd1);
            checkOutput("orderData", {96'd0, respData}, 128'h1000_0000 + i);
            checkOutput("orderId", {123'd0, respRegId}, 128'(i + 1));
            respYumi = 1'b1;
            tick();
            respYumi = 1'b0;
        end
        checkOutput("drainedV", {127'd0, respV}, 128'd0);

        // Simultaneous fwd and rev handshakes at credits=8
        for (int i = 0; i < 3; i++)
            returnResponse(32'h2000_0000 + i, 5'd10);
        respYumi = 1'b1;
        tick();
        tick();
        tick();
        respYumi = 1'b0;
        checkOutput("credits8", {123'd0, outCredits}, 128'd8);
        applyStimulus(32'h0000_0400);
        applyStimulus(32'h0000_0401);
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_0101);
        checkOutput("bothFwdV", {127'd0, outFwdV}, 128'd1);
        inRevV   = 1'b1;
        inRevPkt = {32'hABCD_0001, 5'd20, 3'd0, 4'd0};
        tick();
        inRevV = 1'b0;
        checkOutput("bothCredits", {123'd0, outCredits}, 128'd8);
        checkOutput("bothHostReady", {127'd0, hostReady}, 128'd1);
        checkOutput("bothRespV", {127'd0, respV}, 128'd1);
        inRevV   = 1'b1;
        inRevPkt = {32'hABCD_0002, 5'd21, 3'd0, 4'd0};
        respYumi = 1'b1;
        tick();
        inRevV   = 1'b0;
        respYumi = 1'b0;
        checkOutput("pushPopV", {127'd0, respV}, 128'd1);
        checkOutput("pushPopData", {96'd0, respData}, 128'hABCD_0002);
        checkOutput("pushPopCredits", {123'd0, outCredits}, 128'd9);
        respYumi = 1'b1;
        tick();
        respYumi = 1'b0;
        checkOutput("pushPopDrained", {127'd0, respV}, 128'd0);

        // Reset in the middle of collection
        fwdReadyIn = 1'b0;
        applyStimulus(32'h0000_0055);
        applyStimulus(32'h0000_0066);
        resetN = 1'b0;
        #2;
        checkOutput("midRstHostReady", {127'd0, hostReady}, 128'd1);
        checkOutput("midRstFwdV", {127'd0, outFwdV}, 128'd0);
        checkOutput("midRstCredits", {123'd0, outCredits}, 128'd16);
        checkOutput("midRstDrop", {112'd0, dropCount}, 128'd0);
        checkOutput("midRstRespV", {127'd0, respV}, 128'd0);
        #1;
        resetN = 1'b1;
        tick();
        applyStimulus(32'h0000_002A);
        applyStimulus(32'h1234_5678);
        applyStimulus(32'h0005_0003);
        checkOutput("freshNotYet", {127'd0, outFwdV}, 128'd0);
        applyStimulus(32'h0007_0003);
        expPkt = {28'h2A, 2'b00, 4'h3, 5'd7, 32'h12345678, 3'd0, 4'd0, 3'd5, 4'd3};
        checkOutput("freshFwdV", {127'd0, outFwdV}, 128'd1);
        checkOutput("freshPkt", {43'd0, outFwdPkt}, {43'd0, expPkt});
        fwdReadyIn = 1'b1;
        tick();
        checkOutput("freshCredits", {123'd0, outCredits}, 128'd15);
        checkOutput("freshHostReady", {127'd0, hostReady}, 128'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
